ex_multicycle: RTL and testbench

EX_MULTICYCLE -- requirements
Module: ex_multicycle

---
 rtl/ex_multicycle_pkg.sv | 33 +++
 rtl/ex_muldiv_iter.sv | 70 +++++++
 rtl/ex_multicycle.sv | 149 ++++++++++++++
 tb/tb_ex_multicycle.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_multicycle_pkg.sv
// Shared definitions for the multi-cycle execute stage: R-type function codes,
// FSM state encoding and the iterative mul/div operation select.
package ex_multicycle_pkg;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_OR    = 6'h25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_DIVU  = 1'b1
    } md_op_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// done is asserted during the final iteration; hi/lo hold the result afterwards.
module ex_muldiv_iter
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  md_op_t            op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  count;
    md_op_t            op_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_trial;

    assign done = busy && (count == CNT_W'(DATA_W - 1));

    // Partial remainder stays below the divisor, so bit DATA_W of the trial is a true borrow.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        div_trial = {hi, lo[DATA_W-1]} - {1'b0, b_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            count <= '0;
        end else if (busy) begin
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start && !busy) begin
            op_q <= op;
            b_q  <= operand_b;
            hi   <= '0;
            lo   <= operand_a;
        end else if (busy) begin
            if (op_q == MD_MULTU) begin
                {hi, lo} <= {mul_sum, lo[DATA_W-1:1]};
            end else if (!div_trial[DATA_W]) begin
                hi <= div_trial[DATA_W-1:0];
                lo <= {lo[DATA_W-2:0], 1'b1};
            end else begin
                hi <= {hi[DATA_W-2:0], lo[DATA_W-1]};
                lo <= {lo[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_multicycle.sv
// Execute stage for MIPS R-type ops: single-cycle ALU/shift/HI-LO moves plus
// iterative MULTU/DIVU that stall upstream until the result commits to HI/LO.
module ex_multicycle
    import ex_multicycle_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic [4:0]        shamt,
    input  logic              write_reg_en_in,
    input  logic [REG_AW-1:0] write_reg_addr_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic              write_reg_en_out,
    output logic [REG_AW-1:0] write_reg_addr_out
);

    localparam int SH_W = $clog2(DATA_W);

    state_t                   state;
    logic [DATA_W-1:0]        hi;
    logic [DATA_W-1:0]        lo;
    logic signed [DATA_W-1:0] op2_s;
    logic [SH_W-1:0]          var_amt;
    logic [DATA_W-1:0]        alu_res;
    logic                     alu_wen;
    logic                     accept;
    logic                     md_start;
    md_op_t                   md_op;
    logic                     md_busy;
    logic                     md_done;
    logic [DATA_W-1:0]        md_hi;
    logic [DATA_W-1:0]        md_lo;

    assign accept   = valid_in && !stall_out;
    assign md_start = accept && (state == ST_IDLE) && ((funct == F_MULTU) || (funct == F_DIVU));
    assign md_op    = (funct == F_DIVU) ? MD_DIVU : MD_MULTU;
    assign op2_s    = operand_2;
    assign var_amt  = operand_1[SH_W-1:0];

    // Unknown codes fall through to a zero, non-writing result.
    always_comb begin
        alu_res = '0;
        alu_wen = 1'b1;
        case (funct)
            F_OR:    alu_res = operand_1 | operand_2;
            F_ADDU:  alu_res = operand_1 + operand_2;
            F_SUBU:  alu_res = operand_1 - operand_2;
            F_SLL:   alu_res = operand_2 << shamt;
            F_SRL:   alu_res = operand_2 >> shamt;
            F_SRA:   alu_res = op2_s >>> shamt;
            F_SLLV:  alu_res = operand_2 << var_amt;
            F_SRLV:  alu_res = operand_2 >> var_amt;
            F_SRAV:  alu_res = op2_s >>> var_amt;
            F_MFHI:  alu_res = hi;
            F_MFLO:  alu_res = lo;
            default: alu_wen = 1'b0;
        endcase
    end

    ex_muldiv_iter #(
        .DATA_W(DATA_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start),
        .op       (md_op),
        .operand_a(operand_1),
        .operand_b(operand_2),
        .busy     (md_busy),
        .done     (md_done),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            stall_out          <= 1'b0;
            valid_out          <= 1'b0;
            write_reg_en_out   <= 1'b0;
            result_out         <= '0;
            write_reg_addr_out <= '0;
            hi                 <= '0;
            lo                 <= '0;
        end else begin
            valid_out        <= 1'b0;
            write_reg_en_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        write_reg_addr_out <= write_reg_addr_in;
                        case (funct)
                            F_MULTU: begin
                                state     <= ST_MUL;
                                stall_out <= 1'b1;
                            end
                            F_DIVU: begin
                                state     <= ST_DIV;
                                stall_out <= 1'b1;
                            end
                            F_MTHI: begin
                                hi        <= operand_1;
                                valid_out <= 1'b1;
                            end
                            F_MTLO: begin
                                lo        <= operand_1;
                                valid_out <= 1'b1;
                            end
                            default: begin
                                result_out       <= alu_res;
                                valid_out        <= 1'b1;
                                write_reg_en_out <= write_reg_en_in && alu_wen;
                            end
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    // Engine idle without finishing can only follow an abort; drop back safely.
                    if (md_done) begin
                        state     <= ST_DONE;
                        valid_out <= 1'b1;
                    end else if (!md_busy) begin
                        state     <= ST_IDLE;
                        stall_out <= 1'b0;
                    end
                end
                ST_DONE: begin
                    hi        <= md_hi;
                    lo        <= md_lo;
                    state     <= ST_IDLE;
                    stall_out <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    stall_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_multicycle.sv
// Scoreboard bench for ex_multicycle: directed vectors push expected outputs,
// a negedge monitor pops and compares whenever valid_out is seen.
module tb_ex_multicycle;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [5:0]        funct;
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic [4:0]        shamt;
    logic              write_reg_en_in;
    logic [REG_AW-1:0] write_reg_addr_in;
    logic              stall_out;
    logic              valid_out;
    logic [DATA_W-1:0] result_out;
    logic              write_reg_en_out;
    logic [REG_AW-1:0] write_reg_addr_out;

    ex_multicycle #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_in          (valid_in),
        .funct             (funct),
        .operand_1         (operand_1),
        .operand_2         (operand_2),
        .shamt             (shamt),
        .write_reg_en_in   (write_reg_en_in),
        .write_reg_addr_in (write_reg_addr_in),
        .stall_out         (stall_out),
        .valid_out         (valid_out),
        .result_out        (result_out),
        .write_reg_en_out  (write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        chk_res;
        logic        wen;
        logic [4:0]  waddr;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && valid_out) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got result %h at cycle %0d, expected no output",
                         result_out, cyc);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                check({e.name, "_wen"}, 64'(write_reg_en_out), 64'(e.wen));
                if (e.chk_res) check({e.name, "_result"}, 64'(result_out), 64'(e.res));
                if (e.wen) check({e.name, "_waddr"}, 64'(write_reg_addr_out), 64'(e.waddr));
            end
        end else if (!rst && write_reg_en_out) begin
            tests++;
            fails++;
            $display("FAIL stray_wen: got write_reg_en_out=1 with valid_out=0, expected 0");
        end
    end

    // Presents an instruction and holds it until accepted; extra = cycles beyond one.
    task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] wa,
                         input logic [31:0] res, input logic chk, input logic exp_wen,
                         input int extra);
        exp_t e;
        int n;
        funct             = f;
        operand_1         = a;
        operand_2         = b;
        shamt             = sh;
        write_reg_en_in   = 1'b1;
        write_reg_addr_in = wa;
        valid_in          = 1'b1;
        n = 0;
        while (stall_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall_out) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: got stall_out=1 after %0d cycles, expected 0", name, n);
        end
        e.res     = res;
        e.chk_res = chk;
        e.wen     = exp_wen;
        e.waddr   = wa;
        e.cyc     = cyc + 1 + extra;
        e.name    = name;
        sbq.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic alu(input string name, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [4:0] wa,
                       input logic [31:0] res);
        issue(name, f, a, b, sh, wa, res, 1'b1, 1'b1, 0);
    endtask

    task automatic muldiv(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        issue(name, f, a, b, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, DATA_W);
        n = 0;
        while (stall_out && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, 64'(n), 64'(DATA_W + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; valid_in = 1'b0; funct = '0; operand_1 = '0; operand_2 = '0;
        shamt = '0; write_reg_en_in = 1'b0; write_reg_addr_in = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_result", 64'(result_out), 64'd0);
        check("rst_waddr", 64'(write_reg_addr_out), 64'd0);
        check("rst_wen", 64'(write_reg_en_out), 64'd0);
        rst = 1'b0;

        alu("srav", 6'h07, 32'd4, 32'h8000_0000, 5'd0, 5'd3, 32'hF800_0000);
        alu("or",   6'h25, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 5'd4, 32'hF0F0_0F0F);
        alu("addu_wrap", 6'h21, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5, 32'd0);
        alu("subu_wrap", 6'h23, 32'd0, 32'd1, 5'd0, 5'd6, 32'hFFFF_FFFF);
        alu("sll",  6'h00, 32'd0, 32'h0000_00F1, 5'd4, 5'd7, 32'h0000_0F10);
        alu("srl",  6'h02, 32'd0, 32'h8000_1200, 5'd8, 5'd8, 32'h0080_0012);
        alu("sra",  6'h03, 32'd0, 32'h8000_0000, 5'd4, 5'd9, 32'hF800_0000);
        alu("sllv_mask", 6'h04, 32'h0000_0021, 32'd3, 5'd0, 5'd10, 32'd6);
        alu("srlv", 6'h06, 32'd31, 32'h8000_0000, 5'd0, 5'd11, 32'd1);
        issue("unknown", 6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 5'd12, 32'd0, 1'b1, 1'b0, 0);
        issue("mthi", 6'h11, 32'h0000_1234, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
        issue("mtlo", 6'h13, 32'h0000_5678, 32'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
        alu("mfhi_mt", 6'h10, 32'd0, 32'd0, 5'd0, 5'd13, 32'h0000_1234);
        alu("mflo_mt", 6'h12, 32'd0, 32'd0, 5'd0, 5'd14, 32'h0000_5678);

        muldiv("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        alu("mfhi_mul", 6'h10, 32'd0, 32'd0, 5'd0, 5'd15, 32'hFFFF_FFFE);
        alu("mflo_mul", 6'h12, 32'd0, 32'd0, 5'd0, 5'd16, 32'h0000_0001);

        issue("divu", 6'h1B, 32'd100, 32'd7, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, DATA_W);
        alu("mflo_div_held", 6'h12, 32'd0, 32'd0, 5'd0, 5'd17, 32'd14);
        alu("mfhi_div", 6'h10, 32'd0, 32'd0, 5'd0, 5'd18, 32'd2);

        muldiv("divu_zero", 6'h1B, 32'd5, 32'd0);
        alu("mflo_dz", 6'h12, 32'd0, 32'd0, 5'd0, 5'd19, 32'hFFFF_FFFF);
        alu("mfhi_dz", 6'h10, 32'd0, 32'd0, 5'd0, 5'd20, 32'd5);

        issue("multu_abort", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, DATA_W);
        repeat (9) @(negedge clk);
        check("abort_stall_before", 64'(stall_out), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        sbq.delete();
        check("abort_stall", 64'(stall_out), 64'd0);
        check("abort_valid", 64'(valid_out), 64'd0);
        check("abort_result", 64'(result_out), 64'd0);
        rst = 1'b0;
        alu("mfhi_abort", 6'h10, 32'd0, 32'd0, 5'd0, 5'd21, 32'd0);
        alu("mflo_abort", 6'h12, 32'd0, 32'd0, 5'd0, 5'd22, 32'd0);

        repeat (3) @(negedge clk);
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
